decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised fetch-to-decode buffer and registered decoder for the RV32I pipeline, with optional M-extension decode. It sits between instruction fetch and the ID/EX register. It accepts {pc, instruction} pairs through a valid/ready handshake and holds them in a DEPTH-entry FIFO. It decodes the FIFO head into the pipeline `ctrl_word` plus extended fields, and presents the result from a registered output stage with its own valid/ready handshake, flush support and illegal-instruction detection.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2 (the output register is an additional entry).
- M_EXT, 1, 1 = decode MUL/DIV (op_reg, funct7 = 0000001); 0 = flag those encodings illegal.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents pc/instr.
- in_ready  out  1  FIFO can accept: count < DEPTH and no flush.
- in_pc  in  32  instruction address.
- in_instr  in  32  instruction word.
- flush  in  1  synchronous discard of all buffered and output state.
- out_valid  out  1  output register holds a decoded instruction.
- out_ready  in  1  ID/EX consumes the output this cycle.
- out_pc / out_instr  out  32 each  pass-through of the decoded entry.
- out_ctrl  out  ctrl_word  control word (alumux1/2, cmpmux, aluop, cmpop, dcache_read/write, regfilemux_sel, load_regfile).
- out_rd / out_rs1 / out_rs2  out  5 each  instr[11:7], [19:15], [24:20]; out_rd is forced 0 when load_regfile = 0.
- out_muldiv  out  1  M-extension instruction.
- out_muldiv_op  out  3  funct3 of the M instruction; 0 otherwise.
- out_illegal  out  1  undecodable encoding.
- count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register.

## Operation
- FIFO: circular buffer with wrapping read/write pointers of width $clog2(DEPTH) and a separate count.
  - Push on in_valid & in_ready.
  - Pop when head exists and (!out_valid | out_ready). The popped head is decoded combinationally and loaded into the output register.
  - Simultaneous push and pop leaves count unchanged.
- Output register: out_valid clears on out_ready when no head exists. Contents hold stable while out_valid & !out_ready.
- Decode table for the base opcodes:
  - lui, auipc, jal, jalr, br, load, store, imm and reg use the existing pipeline control table.
  - Defaults: alumux1 = rs1_out, alumux2 = i_imm, cmpmux = i_imm, aluop = add, cmpop = blt, regfilemux = alu_out, all enables 0.
- Decode corrections and extensions:
  - op_reg, funct3 000, funct7 0100000 → alu_sub.
  - op_reg / op_imm, funct3 101, funct7 0100000 → alu_sra.
  - slt / sltu → cmpop blt / bltu and regfilemux = br_en.
  - op_reg, funct7 0000001, M_EXT = 1 → out_muldiv = 1, out_muldiv_op = funct3, load_regfile = 1, regfilemux = alu_out, aluop = add.
- Illegal encodings:
  - Opcode not one of the nine above, including op_csr and all-zero.
  - br with funct3 010 or 011.
  - load with funct3 011, 110 or 111.
  - store with funct3 ≥ 011.
  - op_imm funct3 001 with funct7 ≠ 0.
  - op_imm funct3 101 with funct7 ∉ {0000000, 0100000}.
  - op_reg with funct7 ∉ {0000000, 0100000 (funct3 000 or 101 only), 0000001 (M_EXT only)}.
- Illegal instructions: out_illegal = 1; dcache_read, dcache_write, load_regfile and out_muldiv all 0. They are still delivered in program order.

## Timing
- Reset (async, while rst = 1):
  - Pointers, count and out_valid are 0.
  - out_ctrl equals the defaults; out_pc, out_instr, rd/rs1/rs2, muldiv fields and out_illegal are 0.
  - in_ready = 0 while rst is high, and 1 on the first cycle after release.
- Latency: an instruction pushed at edge E is popped at E+1 at the earliest, so out_valid is high from E+1. Minimum latency is 2 edges; there is no FIFO bypass.
- Throughput: 1 instruction/cycle sustained when out_ready is held 1.
- in_ready does not depend on out_ready. When the FIFO is full, in_ready = 0 even if a pop occurs in the same cycle.
- Flush has highest priority:
  - At the edge it clears pointers, count and out_valid.
  - An in_valid presented in the flush cycle is not accepted (in_ready = 0).
  - out_ready in the flush cycle is don't-care.
- Wrap-around: pointers wrap at DEPTH with no bubble.
- Reset asserted mid-transfer discards all entries immediately.

## Test plan
- Reset release, push addi x1,x0,5 (0x00500093, pc 0x60) with out_ready = 1 → out_valid at edge 2:
  - out_pc = 0x60, out_rd = 1, out_rs1 = 0, aluop = add, alumux2 = i_imm, load_regfile = 1, out_illegal = 0.
- Push sub x3,x1,x2 (0x402081B3) → aluop = alu_sub, alumux2 = rs2_out, out_rd = 3.
- Push mul x5,x6,x7 (0x027302B3):
  - M_EXT = 1 → out_muldiv = 1, out_muldiv_op = 0, out_rd = 5.
  - M_EXT = 0 → out_illegal = 1, load_regfile = 0, out_rd = 0.
- Push 0x00000000 and beq-with-funct3-010 (0x00002063) → both out_illegal = 1, dcache_read/dcache_write = 0, delivered in order.
- Backpressure with DEPTH = 4 and out_ready = 0, pushing 6 instructions:
  - 5 are accepted (4 in FIFO plus the output register); count = 4; in_ready = 0.
  - Raise out_ready → 5 outputs in push order with pcs matching; pointers wrap cleanly.
- Flush with 3 buffered instructions while in_valid = 1 → next cycle count = 0, out_valid = 0; the instruction offered in the flush cycle never appears at the output.

Source files
------------

// File: rtl/decode_queue.sv
// Fetch-to-decode FIFO with a registered RV32I(+M) decoder on the output side.
// The control word layout and its select encodings are shared with the ID/EX stage.
package decode_queue_pkg;
    typedef enum logic [0:0] {a1_rs1_out = 1'b0, a1_pc_out = 1'b1} alumux1_sel_t;
    typedef enum logic [2:0] {
        a2_i_imm = 3'd0, a2_u_imm = 3'd1, a2_b_imm = 3'd2,
        a2_s_imm = 3'd3, a2_j_imm = 3'd4, a2_rs2_out = 3'd5
    } alumux2_sel_t;
    typedef enum logic [0:0] {cm_rs2_out = 1'b0, cm_i_imm = 1'b1} cmpmux_sel_t;
    typedef enum logic [2:0] {
        alu_add = 3'd0, alu_sll = 3'd1, alu_sra = 3'd2, alu_sub = 3'd3,
        alu_xor = 3'd4, alu_srl = 3'd5, alu_or = 3'd6, alu_and = 3'd7
    } alu_ops_t;
    typedef enum logic [2:0] {
        beq = 3'd0, bne = 3'd1, blt = 3'd4, bge = 3'd5, bltu = 3'd6, bgeu = 3'd7
    } branch_funct3_t;
    typedef enum logic [3:0] {
        rf_alu_out = 4'd0, rf_br_en = 4'd1, rf_u_imm = 4'd2, rf_lw = 4'd3,
        rf_pc_plus4 = 4'd4, rf_lb = 4'd5, rf_lbu = 4'd6, rf_lh = 4'd7, rf_lhu = 4'd8
    } regfilemux_sel_t;

    typedef struct packed {
        alumux1_sel_t    alumux1;
        alumux2_sel_t    alumux2;
        cmpmux_sel_t     cmpmux;
        alu_ops_t        aluop;
        branch_funct3_t  cmpop;
        logic            dcache_read;
        logic            dcache_write;
        regfilemux_sel_t regfilemux_sel;
        logic            load_regfile;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_DEFAULT = '{
        alumux1: a1_rs1_out, alumux2: a2_i_imm, cmpmux: cm_i_imm, aluop: alu_add,
        cmpop: blt, dcache_read: 1'b0, dcache_write: 1'b0,
        regfilemux_sel: rf_alu_out, load_regfile: 1'b0
    };
endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int M_EXT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output ctrl_word_t                 out_ctrl,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic                       out_muldiv,
    output logic [2:0]                 out_muldiv_op,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    typedef struct packed {
        ctrl_word_t ctrl;
        logic       muldiv;
        logic [2:0] muldiv_op;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        d.ctrl      = CTRL_DEFAULT;
        d.muldiv    = 1'b0;
        d.muldiv_op = 3'd0;
        d.illegal   = 1'b0;
        case (ins[6:0])
            OP_LUI: begin
                d.ctrl.load_regfile   = 1'b1;
                d.ctrl.regfilemux_sel = rf_u_imm;
            end
            OP_AUIPC: begin
                d.ctrl.alumux1      = a1_pc_out;
                d.ctrl.alumux2      = a2_u_imm;
                d.ctrl.load_regfile = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                d.ctrl.alumux1        = (ins[3]) ? a1_pc_out : a1_rs1_out;
                d.ctrl.alumux2        = (ins[3]) ? a2_j_imm : a2_i_imm;
                d.ctrl.load_regfile   = 1'b1;
                d.ctrl.regfilemux_sel = rf_pc_plus4;
            end
            OP_BR: begin
                d.ctrl.alumux1 = a1_pc_out;
                d.ctrl.alumux2 = a2_b_imm;
                d.ctrl.cmpmux  = cm_rs2_out;
                d.ctrl.cmpop   = branch_funct3_t'(f3);
                d.illegal      = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LOAD: begin
                d.ctrl.dcache_read  = 1'b1;
                d.ctrl.load_regfile = 1'b1;
                case (f3)
                    3'b000:  d.ctrl.regfilemux_sel = rf_lb;
                    3'b001:  d.ctrl.regfilemux_sel = rf_lh;
                    3'b010:  d.ctrl.regfilemux_sel = rf_lw;
                    3'b100:  d.ctrl.regfilemux_sel = rf_lbu;
                    3'b101:  d.ctrl.regfilemux_sel = rf_lhu;
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                d.ctrl.alumux2      = a2_s_imm;
                d.ctrl.dcache_write = 1'b1;
                d.illegal           = (f3 >= 3'b011);
            end
            OP_IMM, OP_REG: begin
                d.ctrl.load_regfile = 1'b1;
                if (ins[5]) begin
                    d.ctrl.alumux2 = a2_rs2_out;
                    d.ctrl.cmpmux  = cm_rs2_out;
                end
                // For op_imm, funct7 only qualifies shifts; elsewhere it is immediate bits.
                if (ins[5] && f7 == 7'b0000001) begin
                    if (M_EXT != 0) begin
                        d.muldiv    = 1'b1;
                        d.muldiv_op = f3;
                    end else begin
                        d.illegal = 1'b1;
                    end
                end else if (ins[5] && f7 != 7'b0000000 &&
                             !(f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    d.illegal = 1'b1;
                end else if (!ins[5] && f3 == 3'b001 && f7 != 7'b0000000) begin
                    d.illegal = 1'b1;
                end else if (!ins[5] && f3 == 3'b101 &&
                             f7 != 7'b0000000 && f7 != 7'b0100000) begin
                    d.illegal = 1'b1;
                end else begin
                    case (f3)
                        3'b000: d.ctrl.aluop = (ins[5] && f7[5]) ? alu_sub : alu_add;
                        3'b010: begin
                            d.ctrl.cmpop          = blt;
                            d.ctrl.regfilemux_sel = rf_br_en;
                        end
                        3'b011: begin
                            d.ctrl.cmpop          = bltu;
                            d.ctrl.regfilemux_sel = rf_br_en;
                        end
                        3'b101:  d.ctrl.aluop = f7[5] ? alu_sra : alu_srl;
                        default: d.ctrl.aluop = alu_ops_t'(f3);
                    endcase
                end
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.ctrl      = CTRL_DEFAULT;
            d.muldiv    = 1'b0;
            d.muldiv_op = 3'd0;
        end
        return d;
    endfunction

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [31:0]   head_instr;
    dec_t          head_dec;

    assign in_ready   = !rst && !flush && (count != CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (count != '0) && (!out_valid || out_ready);
    assign head_instr = mem_instr[rd_ptr];

    always_comb begin
        head_dec = decode(head_instr);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_instr     <= '0;
            out_ctrl      <= CTRL_DEFAULT;
            out_rd        <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_muldiv    <= 1'b0;
            out_muldiv_op <= '0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            // Output stage: load the decoded head, or drain once consumed.
            if (pop) begin
                out_valid     <= 1'b1;
                out_pc        <= mem_pc[rd_ptr];
                out_instr     <= head_instr;
                out_ctrl      <= head_dec.ctrl;
                out_rd        <= head_dec.ctrl.load_regfile ? head_instr[11:7] : 5'd0;
                out_rs1       <= head_instr[19:15];
                out_rs2       <= head_instr[24:20];
                out_muldiv    <= head_dec.muldiv;
                out_muldiv_op <= head_dec.muldiv_op;
                out_illegal   <= head_dec.illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode results, latency, backpressure, flush and reset.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_pc, in_instr;
    logic        in_ready, out_valid, out_muldiv, out_illegal;
    logic [31:0] out_pc, out_instr;
    ctrl_word_t  out_ctrl;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_muldiv_op;
    logic [2:0]  count;
    logic        in_ready0, out_valid0, out_muldiv0, out_illegal0;
    logic [31:0] out_pc0, out_instr0;
    ctrl_word_t  out_ctrl0;
    logic [4:0]  out_rd0, out_rs10, out_rs20;
    logic [2:0]  out_muldiv_op0;
    logic [2:0]  count0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(4), .M_EXT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_ctrl(out_ctrl),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_muldiv(out_muldiv),
        .out_muldiv_op(out_muldiv_op), .out_illegal(out_illegal), .count(count)
    );

    decode_queue #(.DEPTH(4), .M_EXT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid0),
        .out_ready(out_ready), .out_pc(out_pc0), .out_instr(out_instr0), .out_ctrl(out_ctrl0),
        .out_rd(out_rd0), .out_rs1(out_rs10), .out_rs2(out_rs20), .out_muldiv(out_muldiv0),
        .out_muldiv_op(out_muldiv_op0), .out_illegal(out_illegal0), .count(count0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
        step();
        in_valid = 1'b0;
        step();
    endtask

    ctrl_word_t exp_default;
    logic [31:0] bp_instr;

    initial begin
        exp_default = '{alumux1: a1_rs1_out, alumux2: a2_i_imm, cmpmux: cm_i_imm,
                        aluop: alu_add, cmpop: blt, dcache_read: 1'b0, dcache_write: 1'b0,
                        regfilemux_sel: rf_alu_out, load_regfile: 1'b0};
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ctrl", 32'(out_ctrl), 32'(exp_default));
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);

        rst = 1'b0;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);

        // addi x1,x0,5: two edges from push to out_valid
        out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h60; in_instr = 32'h0050_0093;
        step();
        in_valid = 1'b0;
        chk("addi_latency_valid", 32'(out_valid), 32'd0);
        step();
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_pc", out_pc, 32'h60);
        chk("addi_rd", 32'(out_rd), 32'd1);
        chk("addi_rs1", 32'(out_rs1), 32'd0);
        chk("addi_aluop", 32'(out_ctrl.aluop), 32'(alu_add));
        chk("addi_alumux2", 32'(out_ctrl.alumux2), 32'(a2_i_imm));
        chk("addi_load_rf", 32'(out_ctrl.load_regfile), 32'd1);
        chk("addi_illegal", 32'(out_illegal), 32'd0);

        push_one(32'h64, 32'h4020_81B3);
        chk("sub_aluop", 32'(out_ctrl.aluop), 32'(alu_sub));
        chk("sub_alumux2", 32'(out_ctrl.alumux2), 32'(a2_rs2_out));
        chk("sub_rd", 32'(out_rd), 32'd3);

        push_one(32'h68, 32'h0273_02B3);
        chk("mul_muldiv", 32'(out_muldiv), 32'd1);
        chk("mul_op", 32'(out_muldiv_op), 32'd0);
        chk("mul_rd", 32'(out_rd), 32'd5);
        chk("mul_illegal", 32'(out_illegal), 32'd0);
        chk("mul_noM_illegal", 32'(out_illegal0), 32'd1);
        chk("mul_noM_load_rf", 32'(out_ctrl0.load_regfile), 32'd0);
        chk("mul_noM_rd", 32'(out_rd0), 32'd0);
        chk("mul_noM_muldiv", 32'(out_muldiv0), 32'd0);

        // Two illegal encodings back to back, delivered in order
        in_valid = 1'b1; in_pc = 32'h70; in_instr = 32'h0000_0000;
        step();
        in_pc = 32'h74; in_instr = 32'h0000_2063;
        step();
        in_valid = 1'b0;
        chk("ill0_pc", out_pc, 32'h70);
        chk("ill0_illegal", 32'(out_illegal), 32'd1);
        chk("ill0_dread", 32'(out_ctrl.dcache_read), 32'd0);
        chk("ill0_dwrite", 32'(out_ctrl.dcache_write), 32'd0);
        step();
        chk("ill1_pc", out_pc, 32'h74);
        chk("ill1_illegal", 32'(out_illegal), 32'd1);
        chk("ill1_dread", 32'(out_ctrl.dcache_read), 32'd0);
        chk("ill1_dwrite", 32'(out_ctrl.dcache_write), 32'd0);
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: 6 offered, 5 accepted
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bp_instr = {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011};
            in_valid = 1'b1; in_pc = 32'h100 + 32'(4 * i); in_instr = bp_instr;
            chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
            step();
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_hold_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("bp_valid%0d", j), 32'(out_valid), 32'd1);
            chk($sformatf("bp_pc%0d", j), out_pc, 32'h100 + 32'(4 * j));
            chk($sformatf("bp_rd%0d", j), 32'(out_rd), 32'(j + 1));
            step();
        end
        chk("bp_empty_valid", 32'(out_valid), 32'd0);
        chk("bp_empty_count", 32'(count), 32'd0);

        // Flush with 3 buffered entries plus the output register
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * k); in_instr = 32'h0050_0093;
            step();
        end
        chk("pre_flush_count", 32'(count), 32'd3);
        in_pc = 32'h300; flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step(); step();
        chk("flush_no_ghost", 32'(out_valid), 32'd0);
        push_one(32'h400, 32'h0050_0093);
        chk("post_flush_pc", out_pc, 32'h400);

        // Asynchronous reset mid-transfer
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h500;
        step(); step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
